// File: rtl/axi_lite_ram_p.sv
// axi_lite_ram_p
// AXI4-Lite slave in front of a word-addressed RAM with byte-lane write strobes.
//
// Ports
//   clk, rst                     : single rising-edge clock; asynchronous active-high reset
//   axi_aw* (valid/ready/addr)   : write-address channel
//   axi_w*  (valid/ready/data/strb) : write-data channel
//   axi_b*  (valid/ready/resp)   : write-response channel
//   axi_ar* (valid/ready/addr)   : read-address channel
//   axi_r*  (valid/ready/data/resp) : read-data channel
//
// Build option
//   AXI_RAM_OOR_ERR_EN : when defined, any address with nonzero bits above the
//   word index is out of range. Such writes leave memory untouched and such
//   reads return zero data; both respond SLVERR. When undefined, the upper
//   address bits are ignored and the address wraps modulo DEPTH words.
//
// Memory contents are deliberately not reset.

module axi_lite_ram_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_W-1:0]     axi_awaddr,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [DATA_W-1:0]     axi_wdata,
  input  logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_W-1:0]     axi_araddr,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_W-1:0]     axi_rdata,
  output logic [1:0]            axi_rresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t r_state, r_state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_full, w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              aw_hs, w_hs, ar_hs;
  logic              wr_commit, wr_oor, rd_oor;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              unused_addr_bits;

  assign axi_awready = !aw_full && !axi_bvalid;
  assign axi_wready  = !w_full && !axi_bvalid;
  assign axi_arready = (r_state == R_IDLE);
  assign axi_rvalid  = (r_state == R_DATA);

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;

  // A channel that handshakes this cycle is used directly, so the write
  // commits on the edge that completes the later of the two handshakes and
  // bvalid follows one cycle later. Reset blocks any commit outright.
  assign wr_commit = !rst && (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr   = aw_full ? aw_addr_q : axi_awaddr;
  assign wr_data   = w_full ? w_data_q : axi_wdata;
  assign wr_strb   = w_full ? w_strb_q : axi_wstrb;
  assign wr_idx    = wr_addr[LSB +: IDX_W];
  assign rd_idx    = axi_araddr[LSB +: IDX_W];

`ifdef AXI_RAM_OOR_ERR_EN
  assign wr_oor = (wr_addr >> (LSB + IDX_W)) != '0;
  assign rd_oor = (axi_araddr >> (LSB + IDX_W)) != '0;
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  // Byte-offset bits (and upper bits when wrapping) carry no meaning here.
  assign unused_addr_bits = ^{wr_addr, axi_araddr};

  // Holding registers for AW and W; each fills on its own handshake and
  // both drain together when the write commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (wr_commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= axi_awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= axi_wdata;
        w_strb_q <= axi_wstrb;
      end
    end
  end

  // Write response; both ready signals are low while bvalid is up, so a new
  // commit can never collide with a pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
    end else if (wr_commit) begin
      axi_bvalid <= 1'b1;
      axi_bresp  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (axi_bready) begin
      axi_bvalid <= 1'b0;
    end
  end

  // Storage array, byte-lane writes, no reset.
  always_ff @(posedge clk) begin
    if (wr_commit && !wr_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (axi_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read data is sampled on the AR handshake edge, so a write committing on
  // that same edge is not visible in this response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      axi_rdata <= rd_oor ? '0 : mem[rd_idx];
      axi_rresp <= rd_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule
